// File: rtl/rc4.sv
// rc4: RC4 keystream generator; byte-serial key load, KSA over a 256x8 state array,
// then one keystream byte strobed every 4 cycles.
module rc4 #(
    parameter int KEY_SIZE = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] password_input,
    output logic       output_ready,
    output logic [7:0] K
);
    localparam int KW = KEY_SIZE > 1 ? $clog2(KEY_SIZE) : 1;
    localparam logic [KW-1:0] KLAST = KW'(KEY_SIZE - 1);

    typedef enum logic [2:0] {
        LOAD_KEY, INIT_S, KSA_J, KSA_SWAP, PRGA_I, PRGA_J, PRGA_SWAP, PRGA_OUT
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      i_q, i_d, j_q, j_d, k_q, k_d;
    logic [KW-1:0]   kidx_q, kidx_d;
    logic            rdy_q, rdy_d;
    logic [7:0]      s_q [256];
    logic [7:0]      key_q [KEY_SIZE];
    logic [7:0]      si, sj, sk, kb;
    logic            klast;

    assign si    = s_q[i_q];
    assign sj    = s_q[j_q];
    assign sk    = s_q[8'(si + sj)];
    assign kb    = key_q[kidx_q];
    assign klast = kidx_q == KLAST;

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        kidx_d  = kidx_q;
        k_d     = k_q;
        rdy_d   = 1'b0;
        case (state_q)
            LOAD_KEY: begin
                kidx_d  = klast ? '0 : kidx_q + 1'b1;
                i_d     = 8'd0;
                state_d = klast ? INIT_S : LOAD_KEY;
            end
            INIT_S: begin
                i_d     = i_q + 8'd1;
                j_d     = 8'd0;
                kidx_d  = '0;
                state_d = i_q == 8'hFF ? KSA_J : INIT_S;
            end
            KSA_J: begin
                j_d     = j_q + si + kb;
                state_d = KSA_SWAP;
            end
            KSA_SWAP: begin
                i_d     = i_q + 8'd1;
                kidx_d  = klast ? '0 : kidx_q + 1'b1;
                j_d     = i_q == 8'hFF ? 8'd0 : j_q;
                state_d = i_q == 8'hFF ? PRGA_I : KSA_J;
            end
            PRGA_I: begin
                i_d     = i_q + 8'd1;
                state_d = PRGA_J;
            end
            PRGA_J: begin
                j_d     = j_q + si;
                state_d = PRGA_SWAP;
            end
            PRGA_SWAP: state_d = PRGA_OUT;
            default: begin
                k_d     = sk;
                rdy_d   = 1'b1;
                state_d = PRGA_I;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= LOAD_KEY;
            i_q     <= 8'd0;
            j_q     <= 8'd0;
            kidx_q  <= '0;
            k_q     <= 8'd0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            kidx_q  <= kidx_d;
            k_q     <= k_d;
            rdy_q   <= rdy_d;
        end
    end

    // Arrays are fully rewritten before use, so they carry no reset; when i==j both writes carry the same value.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (state_q == LOAD_KEY) key_q[kidx_q] <= password_input;
            if (state_q == INIT_S) s_q[i_q] <= i_q;
            if (state_q == KSA_SWAP || state_q == PRGA_SWAP) begin
                s_q[i_q] <= sj;
                s_q[j_q] <= si;
            end
        end
    end

    assign output_ready = rdy_q;
    assign K            = k_q;
endmodule

// File: tb/tb_rc4.sv
// tb_rc4: runs three rc4 instances (KEY_SIZE 3, 4, 6) side by side against known
// vectors and a software RC4 model, including resets mid-KSA and mid-PRGA.
module tb_rc4;
    logic            clk = 1'b0;
    logic            rst;
    logic [2:0][7:0] pw;
    logic [2:0][7:0] kk;
    logic [2:0]      rdy;

    int         errors = 0;
    int         checks = 0;
    int         ks [3] = '{3, 4, 6};
    int         vlen [3] = '{10, 6, 8};
    logic [7:0] vec [3][10] = '{
        '{8'hEB, 8'h9F, 8'h77, 8'h81, 8'hB7, 8'h34, 8'hCA, 8'h72, 8'hA7, 8'h19},
        '{8'h60, 8'h44, 8'hDB, 8'h6D, 8'h41, 8'hB7, 8'h00, 8'h00, 8'h00, 8'h00},
        '{8'h04, 8'hD4, 8'h6B, 8'h05, 8'h3C, 8'hA8, 8'h7B, 8'h59, 8'h00, 8'h00}};
    logic [7:0] cur_key [3][6];
    logic [7:0] mdl [3][512];

    rc4 #(.KEY_SIZE(3)) dut3 (.clk(clk), .rst(rst), .password_input(pw[0]), .output_ready(rdy[0]), .K(kk[0]));
    rc4 #(.KEY_SIZE(4)) dut4 (.clk(clk), .rst(rst), .password_input(pw[1]), .output_ready(rdy[1]), .K(kk[1]));
    rc4 #(.KEY_SIZE(6)) dut6 (.clk(clk), .rst(rst), .password_input(pw[2]), .output_ready(rdy[2]), .K(kk[2]));

    always #5 clk = ~clk;

    task automatic compute_model(input int n);
        logic [7:0] s [256];
        logic [7:0] t;
        int a, b;
        for (int x = 0; x < 256; x++) s[x] = 8'(x);
        b = 0;
        for (a = 0; a < 256; a++) begin
            b = (b + s[a] + cur_key[n][a % ks[n]]) % 256;
            t = s[a]; s[a] = s[b]; s[b] = t;
        end
        a = 0;
        b = 0;
        for (int c = 0; c < 512; c++) begin
            a = (a + 1) % 256;
            b = (b + s[a]) % 256;
            t = s[a]; s[a] = s[b]; s[b] = t;
            mdl[n][c] = s[(s[a] + s[b]) % 256];
        end
    endtask

    task automatic set_named_keys();
        cur_key[0] = '{8'h4B, 8'h65, 8'h79, 8'h00, 8'h00, 8'h00};
        cur_key[1] = '{8'h57, 8'h69, 8'h6B, 8'h69, 8'h00, 8'h00};
        cur_key[2] = '{8'h53, 8'h65, 8'h63, 8'h72, 8'h65, 8'h74};
        for (int n = 0; n < 3; n++) compute_model(n);
    endtask

    task automatic reset_pulse(input int cycles);
        rst = 1'b0;
        pw  = {$urandom, $urandom, $urandom};
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk);
            @(negedge clk);
            for (int n = 0; n < 3; n++) begin
                checks++;
                if (rdy[n] !== 1'b0 || kk[n] !== 8'h00)
                    $display("FAIL reset inst%0d got rdy=%b K=%h want rdy=0 K=00", n, rdy[n], kk[n]);
                if (rdy[n] !== 1'b0 || kk[n] !== 8'h00) errors++;
            end
        end
    endtask

    // Releases reset, streams the key, then watches every instance for ncyc edges.
    task automatic run(input int ncyc, input bit use_vec, input int stop_after);
        int         idx [3];
        int         last [3];
        logic [7:0] held [3];
        int         f, want;
        bit         stopped = 1'b0;
        for (int n = 0; n < 3; n++) begin
            idx[n] = 0; last[n] = 0; held[n] = 8'h00;
            pw[n] = cur_key[n][0];
        end
        rst = 1'b1;
        for (int e = 1; e <= ncyc; e++) begin
            @(posedge clk);
            @(negedge clk);
            for (int n = 0; n < 3; n++) begin
                if (rdy[n]) begin
                    checks++;
                    if (kk[n] !== mdl[n][idx[n]]) begin
                        errors++;
                        $display("FAIL model_byte inst%0d idx=%0d got=%h want=%h", n, idx[n], kk[n], mdl[n][idx[n]]);
                    end
                    if (use_vec && idx[n] < vlen[n]) begin
                        checks++;
                        if (kk[n] !== vec[n][idx[n]]) begin
                            errors++;
                            $display("FAIL vector_byte inst%0d idx=%0d got=%h want=%h", n, idx[n], kk[n], vec[n][idx[n]]);
                        end
                    end
                    want = idx[n] == 0 ? ks[n] + 772 : last[n] + 4;
                    checks++;
                    if (e !== want) begin
                        errors++;
                        $display("FAIL strobe_edge inst%0d idx=%0d got=%0d want=%0d", n, idx[n], e, want);
                    end
                    last[n] = e; held[n] = kk[n]; idx[n]++;
                end else begin
                    checks++;
                    if (kk[n] !== held[n]) begin
                        errors++;
                        $display("FAIL k_stable inst%0d edge=%0d got=%h want=%h", n, e, kk[n], held[n]);
                    end
                end
            end
            if (stop_after > 0 && idx[2] == stop_after) begin
                stopped = 1'b1;
                break;
            end
            for (int n = 0; n < 3; n++) pw[n] = e < ks[n] ? cur_key[n][e] : 8'($urandom);
        end
        if (stop_after > 0) begin
            checks++;
            if (!stopped) begin
                errors++;
                $display("FAIL stop_bytes inst2 got=%0d want=%0d", idx[2], stop_after);
            end
        end else begin
            for (int n = 0; n < 3; n++) begin
                f = ks[n] + 772;
                want = ncyc >= f ? (ncyc - f) / 4 + 1 : 0;
                checks++;
                if (idx[n] !== want) begin
                    errors++;
                    $display("FAIL strobe_count inst%0d got=%0d want=%0d", n, idx[n], want);
                end
            end
        end
    endtask

    task automatic test_reset();
        set_named_keys();
        reset_pulse(5);
    endtask

    task automatic test_known_vectors();
        reset_pulse(1);
        run(812, 1'b1, 0);
    endtask

    task automatic test_mid_reset();
        reset_pulse(1);
        run(6 + 256 + 100, 1'b0, 0);
        reset_pulse(1);
        run(1000, 1'b0, 3);
        reset_pulse(1);
        run(812, 1'b1, 0);
    endtask

    task automatic test_random_keys();
        for (int r = 0; r < 2; r++) begin
            for (int n = 0; n < 3; n++) begin
                for (int b = 0; b < 6; b++) cur_key[n][b] = 8'($urandom);
                compute_model(n);
            end
            reset_pulse(1);
            run(1100, 1'b0, 0);
        end
    endtask

    task automatic test_long_run();
        set_named_keys();
        reset_pulse(1);
        run(2000, 1'b1, 0);
    endtask

    initial begin
        rst = 1'b0;
        pw  = '0;
        test_reset();
        test_known_vectors();
        test_mid_reset();
        test_random_keys();
        test_long_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
